egreedy_nexthop: RTL

Parametrised epsilon-greedy next-hop selector for the Q-routing node. On `start`, it scans up to `MAX_NB` neighbour entries (neighbour ID plus Q-value) from the node's Q-table memory. It then returns either the argmax neighbour (exploit) or a pseudo-randomly chosen neighbour (explore), as decided by an internal LFSR compared against `epsilon`. It sits between the Q-table RAM and the packet-forwarding logic and supersedes the fixed-width, reset-only winner policy.

---
 rtl/qroute_pkg.sv | 22 ++
 rtl/lfsr16.sv | 21 ++
 rtl/egreedy_nexthop.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/qroute_pkg.sv
// Shared Q-routing definitions: sentinel ID, selector modes, LFSR taps and
// the next-hop selector FSM state type.
package qroute_pkg;

  localparam int NO_HOP_DEFAULT = 100;

  localparam logic [1:0] MODE_GREEDY  = 2'd0;
  localparam logic [1:0] MODE_EGREEDY = 2'd1;
  localparam logic [1:0] MODE_EXPLORE = 2'd2;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with SEED on reset.
module lfsr16
  import qroute_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SEED;
    else        state <= {state[14:0], fb};
  end

endmodule

// File: rtl/egreedy_nexthop.sv
// Epsilon-greedy next-hop selector: scans neighbour (ID, Q) pairs from the
// Q-table memory and returns the argmax or an LFSR-chosen neighbour.
module egreedy_nexthop
  import qroute_pkg::*;
#(
  parameter int          WORD_WIDTH = 16,
  parameter int          ADDR_WIDTH = 16,
  parameter int          MAX_NB     = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          NO_HOP     = NO_HOP_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [15:0]               epsilon,
  input  logic [$clog2(MAX_NB):0]   num_nb,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_rd,
  input  logic [WORD_WIDTH-1:0]     mem_data,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_WIDTH-1:0]     nexthop,
  output logic [WORD_WIDTH-1:0]     bestvalue,
  output logic                      explored,
  output state_t                    state_dbg
);

  localparam int NB_W  = $clog2(MAX_NB) + 1;
  localparam int CNT_W = NB_W + 1;
  localparam logic [NB_W-1:0]       MAX_NB_W = NB_W'(MAX_NB);
  localparam logic [WORD_WIDTH-1:0] NO_HOP_W = WORD_WIDTH'(NO_HOP);

  state_t state_q, state_d;

  logic [15:0]           lfsr;
  logic [1:0]            mode_q;
  logic [15:0]           eps_q;
  logic [NB_W-1:0]       n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic                  explore_q;
  logic [NB_W-1:0]       ri_q;
  logic                  pend_q;
  logic [CNT_W-1:0]      pend_idx_q;
  logic [WORD_WIDTH-1:0] id_tmp_q;
  logic [WORD_WIDTH-1:0] best_id_q, best_val_q, sel_id_q, sel_val_q;
  logic [WORD_WIDTH-1:0] best_id_d, best_val_d, sel_id_d, sel_val_d;

  logic                  explore_draw;
  logic [NB_W+7:0]       prod;
  logic [NB_W-1:0]       ri_draw;
  logic                  last_rd;
  logic [NB_W-1:0]       entry_idx;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr)
  );

  assign explore_draw = (mode_q == MODE_EXPLORE) ||
                        ((mode_q == MODE_EGREEDY) && (lfsr < eps_q));
  // Scaling the top LFSR byte by n keeps the random index strictly below n.
  assign prod      = {{NB_W{1'b0}}, lfsr[15:8]} * {8'd0, n_q};
  assign ri_draw   = NB_W'(prod >> 8);
  assign last_rd   = (rd_cnt_q == ({n_q, 1'b0} - CNT_W'(1)));
  assign entry_idx = pend_idx_q[CNT_W-1:1];
  assign mem_addr  = addr_q;
  assign state_dbg = state_q;

  // Handshake: start is accepted only in IDLE (ignored while busy or in the
  // done cycle); done pulses one cycle, results valid from that cycle and held
  // until the next done.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_rd  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRAW;
      ST_DRAW: begin
        busy    = 1'b1;
        state_d = (n_q == '0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Odd words are Q-values; the matching ID arrived one cycle earlier.
  always_comb begin
    best_id_d  = best_id_q;
    best_val_d = best_val_q;
    sel_id_d   = sel_id_q;
    sel_val_d  = sel_val_q;
    if (pend_q && pend_idx_q[0]) begin
      if ((entry_idx == '0) || (mem_data > best_val_q)) begin
        best_id_d  = id_tmp_q;
        best_val_d = mem_data;
      end
      if (entry_idx == ri_q) begin
        sel_id_d  = id_tmp_q;
        sel_val_d = mem_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q     <= '0;
      eps_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      explore_q  <= 1'b0;
      ri_q       <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      id_tmp_q   <= '0;
      best_id_q  <= '0;
      best_val_q <= '0;
      sel_id_q   <= '0;
      sel_val_q  <= '0;
      nexthop    <= NO_HOP_W;
      bestvalue  <= '0;
      explored   <= 1'b0;
    end else begin
      pend_q     <= (state_q == ST_SCAN);
      pend_idx_q <= rd_cnt_q;
      if (pend_q && !pend_idx_q[0]) id_tmp_q <= mem_data;
      best_id_q  <= best_id_d;
      best_val_q <= best_val_d;
      sel_id_q   <= sel_id_d;
      sel_val_q  <= sel_val_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            eps_q    <= epsilon;
            n_q      <= (num_nb > MAX_NB_W) ? MAX_NB_W : num_nb;
            addr_q   <= base_addr;
            rd_cnt_q <= '0;
          end
        end
        ST_DRAW: begin
          explore_q <= explore_draw;
          ri_q      <= ri_draw;
          if (n_q == '0) begin
            nexthop   <= NO_HOP_W;
            bestvalue <= '0;
            explored  <= 1'b0;
          end
        end
        ST_SCAN: begin
          addr_q   <= addr_q + ADDR_WIDTH'(1);
          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end
        ST_DRAIN: begin
          nexthop   <= explore_q ? sel_id_d  : best_id_d;
          bestvalue <= explore_q ? sel_val_d : best_val_d;
          explored  <= explore_q;
        end
        default: ;
      endcase
    end
  end

endmodule
